// File: rtl/pic_interrupt_sequencer.sv
// Interrupt acknowledge sequencer and priority resolver for an 8259A-style PIC.
// Picks the highest-priority eligible request, runs the two-pulse INTA handshake,
// sources the vector and maintains the In-Service Register.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   irr_bits            masked pending requests (bit n = IRn)
//   inta_n              CPU acknowledge, active-low, synchronous to clk
//   eoi / seoi          non-specific / specific end-of-interrupt pulses
//   seoi_level          level cleared by seoi
//   auto_eoi, rotate    auto-EOI and rotating-priority modes
//   vector_base         T7..T3 of the vector
//   int_out             interrupt request to CPU
//   isr                 In-Service Register
//   read_priority       freezes IRR during acknowledge
//   clr_irr_valid/level one-cycle IRR clear strobe and its level
//   vector_data/valid   vector and bus-drive enable
module pic_interrupt_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] irr_bits,
  input  logic       inta_n,
  input  logic       eoi,
  input  logic       seoi,
  input  logic [2:0] seoi_level,
  input  logic       auto_eoi,
  input  logic       rotate,
  input  logic [4:0] vector_base,
  output logic       int_out,
  output logic [7:0] isr,
  output logic       read_priority,
  output logic       clr_irr_valid,
  output logic [2:0] clr_irr_level,
  output logic [7:0] vector_data,
  output logic       vector_valid
);

  localparam int unsigned NUM_LVL = 8;
  localparam int unsigned LVL_W   = 3;

  typedef enum logic [1:0] {IDLE, PEND, WAIT2, ACK2} state_e;

  state_e           state_q, state_d;
  logic             inta_q;
  logic [LVL_W-1:0] lp_q, lp_d;
  logic [7:0]       isr_q, isr_d;
  logic             int_out_q, int_out_d;
  logic             rp_q, rp_d;
  logic             clr_valid_q, clr_valid_d;
  logic [LVL_W-1:0] clr_level_q, clr_level_d;
  logic [7:0]       vec_data_q, vec_data_d;
  logic             vec_valid_q, vec_valid_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             spur_q, spur_d;

  logic [3:0]       irr_top, isr_top;
  logic [LVL_W-1:0] irr_rank, isr_rank;
  logic             eligible;
  logic             inta_fall;
  logic [7:0]       set_mask, eoi_mask, aeoi_mask;

  // Returns {found, level} of the highest-priority set bit; priority starts at lp+1.
  // Scans from lowest to highest priority so the last hit is the winner.
  function automatic logic [3:0] pick_top(input logic [7:0] bits, input logic [LVL_W-1:0] lp);
    logic [3:0]       res;
    logic [LVL_W-1:0] idx;
    res = '0;
    for (int k = int'(NUM_LVL) - 1; k >= 0; k--) begin
      idx = LVL_W'(lp + LVL_W'(k) + LVL_W'(1));
      if (bits[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // Priority resolution: rank 0 is highest priority; fully nested against isr.
  always_comb begin
    irr_top   = pick_top(irr_bits, lp_q);
    isr_top   = pick_top(isr_q, lp_q);
    irr_rank  = LVL_W'(irr_top[2:0] - lp_q - LVL_W'(1));
    isr_rank  = LVL_W'(isr_top[2:0] - lp_q - LVL_W'(1));
    eligible  = irr_top[3] && (!isr_top[3] || (irr_rank < isr_rank));
    inta_fall = inta_q & ~inta_n;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (eligible) state_d = PEND;
      PEND: begin
        if (inta_fall)     state_d = WAIT2;
        else if (!eligible) state_d = IDLE;
      end
      WAIT2:   if (inta_fall) state_d = ACK2;
      ACK2:    if (inta_n) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    int_out_d   = int_out_q;
    rp_d        = rp_q;
    clr_valid_d = 1'b0;
    clr_level_d = clr_level_q;
    vec_data_d  = vec_data_q;
    vec_valid_d = vec_valid_q;
    level_d     = level_q;
    spur_d      = spur_q;
    lp_d        = lp_q;
    set_mask    = '0;
    aeoi_mask   = '0;
    eoi_mask    = '0;

    case (state_q)
      IDLE: if (eligible) int_out_d = 1'b1;
      PEND: begin
        if (inta_fall) begin
          int_out_d = 1'b0;
          rp_d      = 1'b1;
          if (eligible) begin
            level_d               = irr_top[2:0];
            spur_d                = 1'b0;
            set_mask[irr_top[2:0]] = 1'b1;
            clr_valid_d           = 1'b1;
            clr_level_d           = irr_top[2:0];
          end else begin
            // Request vanished at the acknowledge: answer with IR7, touch nothing.
            level_d = LVL_W'(7);
            spur_d  = 1'b1;
          end
        end else if (!eligible) begin
          int_out_d = 1'b0;
        end
      end
      WAIT2: begin
        if (inta_fall) begin
          vec_data_d  = {vector_base, level_q};
          vec_valid_d = 1'b1;
        end
      end
      ACK2: begin
        if (inta_n) begin
          vec_valid_d = 1'b0;
          rp_d        = 1'b0;
          if (auto_eoi && !spur_q) begin
            aeoi_mask[level_q] = 1'b1;
            if (rotate) lp_d = level_q;
          end
        end
      end
      default: ;
    endcase

    // EOI works on the pre-update isr; specific EOI wins over non-specific.
    if (seoi) begin
      eoi_mask[seoi_level] = 1'b1;
      if (rotate) lp_d = seoi_level;
    end else if (eoi && isr_top[3]) begin
      eoi_mask[isr_top[2:0]] = 1'b1;
      if (rotate) lp_d = isr_top[2:0];
    end

    isr_d = (isr_q & ~(eoi_mask | aeoi_mask)) | set_mask;
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inta_q      <= 1'b1;
      lp_q        <= LVL_W'(7);
      isr_q       <= '0;
      int_out_q   <= 1'b0;
      rp_q        <= 1'b0;
      clr_valid_q <= 1'b0;
      clr_level_q <= '0;
      vec_data_q  <= '0;
      vec_valid_q <= 1'b0;
      level_q     <= '0;
      spur_q      <= 1'b0;
    end else begin
      inta_q      <= inta_n;
      lp_q        <= lp_d;
      isr_q       <= isr_d;
      int_out_q   <= int_out_d;
      rp_q        <= rp_d;
      clr_valid_q <= clr_valid_d;
      clr_level_q <= clr_level_d;
      vec_data_q  <= vec_data_d;
      vec_valid_q <= vec_valid_d;
      level_q     <= level_d;
      spur_q      <= spur_d;
    end
  end

  assign int_out       = int_out_q;
  assign isr           = isr_q;
  assign read_priority = rp_q;
  assign clr_irr_valid = clr_valid_q;
  assign clr_irr_level = clr_level_q;
  assign vector_data   = vec_data_q;
  assign vector_valid  = vec_valid_q;

endmodule
